alarm_bank: RTL and testbench

Multi-channel alarm controller replacing the single-alarm block of the clock design. Holds NUM_ALARMS independently editable HH:MM alarms with per-channel enable, snooze and a pending queue. Compares against the running time from the timekeeping block on each 1 Hz tick and drives a ring request to the music block. Button inputs arrive from the mode-selection/debounce path as single-cycle pulses.

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/time_add_min.sv | 30 +++
 rtl/alarm_bank.sv | 193 +++++++++++++++++++
 tb/tb_alarm_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the multi-channel alarm bank.
//   state_e  - controller FSM states (IDLE, RINGING)
//   field_e  - edit field select (F_HOUR, F_MIN)
//   hhmm_t   - packed {hour, minute} time of day
//   HOURS / MINS - wrap moduli for hour and minute
//   wrap_step()  - +/-1 with modulo wrap, used by the edit buttons
package alarm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } state_e;

  typedef enum logic {
    F_HOUR = 1'b0,
    F_MIN  = 1'b1
  } field_e;

  localparam logic [4:0] HOURS = 5'd24;
  localparam logic [5:0] MINS  = 6'd60;

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
  } hhmm_t;

  // Step v by one within [0, modulus-1]; inc = 1 counts up, 0 counts down.
  function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                           input logic [5:0] modulus,
                                           input logic       inc);
    if (inc) return (v == modulus - 6'd1) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? modulus - 6'd1 : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_add_min.sv
// time_add_min: combinational hh:mm + k minutes, minute wraps at 60 with
// carry into the hour, hour wraps at 24. k must be 0..59 (at most one carry).
//   i_hour   [4:0]  start hour, 0-23
//   i_minute [5:0]  start minute, 0-59
//   i_add    [5:0]  minutes to add, 0-59
//   o_hour   [4:0]  result hour
//   o_minute [5:0]  result minute
module time_add_min
  import alarm_pkg::*;
(
  input  logic [4:0] i_hour,
  input  logic [5:0] i_minute,
  input  logic [5:0] i_add,
  output logic [4:0] o_hour,
  output logic [5:0] o_minute
);

  logic [6:0] w_msum;
  logic       w_carry;
  logic [5:0] w_hsum;

  assign w_msum   = {1'b0, i_minute} + {1'b0, i_add};
  assign w_carry  = (w_msum >= {1'b0, MINS});
  assign o_minute = w_carry ? 6'(w_msum - {1'b0, MINS}) : w_msum[5:0];

  assign w_hsum   = {1'b0, i_hour} + {5'd0, w_carry};
  assign o_hour   = (w_hsum >= {1'b0, HOURS}) ? 5'(w_hsum - {1'b0, HOURS})
                                               : w_hsum[4:0];

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS independently editable HH:MM alarms with per-channel
// enable, snooze and a pending queue. On each 1 Hz tick with second == 0 the
// running time is compared against every enabled alarm and armed snooze;
// matching channels queue in pend_mask and ring one at a time, lowest first.
//   clk, rst              clock, asynchronous active-high reset
//   tick_1hz              one-cycle strobe per second
//   hour/minute/second    running time of day
//   edit_en, sel          edit mode and channel being edited/displayed
//   up/down/left/right/middle  one-cycle button pulses
//   ring, ring_idx        ring request and the channel ringing
//   field                 edit field (0 = hour, 1 = minute)
//   sel_hour/sel_minute   stored alarm time of channel sel (combinational)
//   en_mask/snooze_mask/pend_mask  per-channel status
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int IW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic [4:0]            hour,
  input  logic [5:0]            minute,
  input  logic [5:0]            second,
  input  logic                  edit_en,
  input  logic [IW-1:0]         sel,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  input  logic                  middle,
  output logic                  ring,
  output logic [IW-1:0]         ring_idx,
  output logic                  field,
  output logic [4:0]            sel_hour,
  output logic [5:0]            sel_minute,
  output logic [NUM_ALARMS-1:0] en_mask,
  output logic [NUM_ALARMS-1:0] snooze_mask,
  output logic [NUM_ALARMS-1:0] pend_mask
);

  localparam logic [7:0] RING_LD = 8'(RING_SEC);
  localparam logic [5:0] SNZ_ADD = 6'(SNOOZE_MIN);

  state_e                r_state, w_state_next;
  field_e                r_field;
  hhmm_t                 r_alarm  [NUM_ALARMS];
  hhmm_t                 r_snooze [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_en, r_snz, r_pend;
  logic [IW-1:0]         r_ring_idx;
  logic [7:0]            r_timer;

  logic [NUM_ALARMS-1:0] w_match, w_snz_hit, w_pend_next, w_snz_next;
  logic [IW-1:0]         w_low;
  logic                  w_start, w_dismiss, w_snooze;
  logic                  w_sel_ok, w_edit, w_disable;
  hhmm_t                 w_now, w_snz_time;
  logic [4:0]            w_snz_hh;
  logic [5:0]            w_snz_mm;

  assign w_now      = {hour, minute};
  assign w_snz_time = {w_snz_hh, w_snz_mm};

  time_add_min u_snz_add (
    .i_hour   (hour),
    .i_minute (minute),
    .i_add    (SNZ_ADD),
    .o_hour   (w_snz_hh),
    .o_minute (w_snz_mm)
  );

  // sel can exceed the channel count when NUM_ALARMS is not a power of two.
  assign w_sel_ok  = (int'(sel) < NUM_ALARMS);
  assign w_edit    = (r_state == IDLE) && edit_en && w_sel_ok;
  assign w_disable = w_edit && middle && r_en[sel];

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_match   = '0;
    w_snz_hit = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (tick_1hz && (second == 6'd0)) begin
        w_snz_hit[i] = r_snz[i] && (r_snooze[i] == w_now);
        w_match[i]   = (r_en[i] && (r_alarm[i] == w_now)) || w_snz_hit[i];
      end
    end
  end

  // Lowest set pend bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_low = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_low = IW'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_dismiss    = 1'b0;
    w_snooze     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|r_pend) begin
          w_start      = 1'b1;
          w_state_next = RINGING;
        end
      end
      RINGING: begin
        if (middle)                                 w_dismiss = 1'b1;
        else if (up || down)                        w_snooze  = 1'b1;
        else if (tick_1hz && (r_timer <= 8'd1))     w_dismiss = 1'b1;
        if (w_dismiss || w_snooze) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Matches are OR'd in after the dequeue so a same-cycle match is never
  // lost; a disable is applied last so a disabled channel cannot stay queued.
  always_comb begin
    w_pend_next = r_pend;
    if (w_start) w_pend_next[w_low] = 1'b0;
    w_pend_next = w_pend_next | w_match;
    if (w_disable) w_pend_next[sel] = 1'b0;

    w_snz_next = r_snz & ~w_snz_hit;
    if (w_snooze)  w_snz_next[r_ring_idx] = 1'b1;
    if (w_disable) w_snz_next[sel]        = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the time arrays are reset on purpose: after reset every alarm and
  // snooze time must read back as 00:00, so they are not left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= '0;
      r_snz      <= '0;
      r_pend     <= '0;
      r_field    <= F_HOUR;
      r_ring_idx <= '0;
      r_timer    <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_alarm[i]  <= '0;
        r_snooze[i] <= '0;
      end
    end else begin
      r_pend <= w_pend_next;
      r_snz  <= w_snz_next;

      if (w_start) begin
        r_ring_idx <= w_low;
        r_timer    <= RING_LD;
      end else if ((r_state == RINGING) && tick_1hz) begin
        r_timer <= r_timer - 8'd1;
      end

      if (w_snooze) r_snooze[r_ring_idx] <= w_snz_time;

      if (w_edit) begin
        if (left || right) r_field <= (r_field == F_HOUR) ? F_MIN : F_HOUR;
        if (middle)        r_en[sel] <= ~r_en[sel];
        // up and down together cancel out.
        if (up != down) begin
          if (r_field == F_HOUR)
            r_alarm[sel].hh <= 5'(wrap_step({1'b0, r_alarm[sel].hh}, {1'b0, HOURS}, up));
          else
            r_alarm[sel].mm <= wrap_step(r_alarm[sel].mm, MINS, up);
        end
      end
    end
  end

  assign ring        = (r_state == RINGING);
  assign ring_idx    = r_ring_idx;
  assign field       = (r_field == F_MIN);
  assign sel_hour    = w_sel_ok ? r_alarm[sel].hh : 5'd0;
  assign sel_minute  = w_sel_ok ? r_alarm[sel].mm : 6'd0;
  assign en_mask     = r_en;
  assign snooze_mask = r_snz;
  assign pend_mask   = r_pend;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed bench for alarm_bank with NUM_ALARMS = 4,
// SNOOZE_MIN = 5, RING_SEC = 3. Inputs change #1 after a rising edge and
// outputs are sampled there as well.
module tb_alarm_bank;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_MID = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0;
  logic [5:0] second = '0;
  logic       edit_en = 1'b0;
  logic [1:0] sel = '0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;

  logic       ring;
  logic [1:0] ring_idx;
  logic       field;
  logic [4:0] sel_hour;
  logic [5:0] sel_minute;
  logic [3:0] en_mask, snooze_mask, pend_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_bank #(
    .NUM_ALARMS (4),
    .SNOOZE_MIN (5),
    .RING_SEC   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .edit_en     (edit_en),
    .sel         (sel),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .middle      (middle),
    .ring        (ring),
    .ring_idx    (ring_idx),
    .field       (field),
    .sel_hour    (sel_hour),
    .sel_minute  (sel_minute),
    .en_mask     (en_mask),
    .snooze_mask (snooze_mask),
    .pend_mask   (pend_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    case (b)
      B_UP:    up = 1'b1;
      B_DOWN:  down = 1'b1;
      B_LEFT:  left = 1'b1;
      B_RIGHT: right = 1'b1;
      default: middle = 1'b1;
    endcase
    clk1();
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; middle = 1'b0;
  endtask

  task automatic press_n(input int b, input int n);
    for (int k = 0; k < n; k++) press(b);
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    hour = 5'(h); minute = 6'(m); second = 6'(s);
    tick_1hz = 1'b1;
    clk1();
    tick_1hz = 1'b0;
  endtask

  initial begin
    // Reset state
    clk1(); clk1();
    check("rst_ring", ring, 0);
    check("rst_idx", ring_idx, 0);
    check("rst_field", field, 0);
    check("rst_en", en_mask, 0);
    check("rst_snz", snooze_mask, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_hour", sel_hour, 0);
    check("rst_min", sel_minute, 0);
    rst = 1'b0;
    clk1();

    // Channel 2 at 07:30, enabled
    edit_en = 1'b1; sel = 2'd2;
    press_n(B_UP, 7);
    press(B_RIGHT);
    check("field_min", field, 1);
    press_n(B_UP, 30);
    press(B_MID);
    press(B_LEFT);
    check("ch2_hour", sel_hour, 7);
    check("ch2_min", sel_minute, 30);
    check("ch2_en", en_mask, 4'b0100);
    check("field_hour", field, 0);
    edit_en = 1'b0;

    tick_at(7, 29, 59);
    check("pre_pend", pend_mask, 0);
    tick_at(7, 30, 0);
    check("match_pend", pend_mask, 4'b0100);
    check("match_ring_lat", ring, 0);
    second = 6'd1;
    clk1();
    check("ring2", ring, 1);
    check("ring2_idx", ring_idx, 2);
    check("ring2_pend", pend_mask, 0);
    press(B_MID);
    check("dismiss2", ring, 0);
    check("dismiss2_pend", pend_mask, 0);
    check("dismiss2_en", en_mask, 4'b0100);

    // Channels 0 and 3 at 06:00
    edit_en = 1'b1;
    sel = 2'd0; press_n(B_UP, 6); press(B_MID);
    sel = 2'd3; press_n(B_UP, 6); press(B_MID);
    edit_en = 1'b0;
    check("en_03", en_mask, 4'b1101);
    tick_at(6, 0, 0);
    check("pend_03", pend_mask, 4'b1001);
    second = 6'd1;
    clk1();
    check("ring0", ring, 1);
    check("ring0_idx", ring_idx, 0);
    check("ring0_pend", pend_mask, 4'b1000);
    press(B_MID);
    check("gap_0_3", ring, 0);
    clk1();
    check("ring3", ring, 1);
    check("ring3_idx", ring_idx, 3);
    check("ring3_pend", pend_mask, 0);
    press(B_MID);
    check("dismiss3", ring, 0);
    clk1();
    check("idle_after_3", ring, 0);

    // Channel 1 at 23:58, then snooze across midnight
    edit_en = 1'b1; sel = 2'd1;
    press(B_DOWN);
    check("hour_dec_wrap", sel_hour, 23);
    press(B_RIGHT);
    press_n(B_DOWN, 2);
    check("ch1_min", sel_minute, 58);
    press(B_MID);
    press(B_LEFT);
    edit_en = 1'b0;
    check("en_all", en_mask, 4'b1111);
    tick_at(23, 58, 0);
    second = 6'd1;
    clk1();
    check("ring1", ring, 1);
    check("ring1_idx", ring_idx, 1);
    press(B_UP);
    check("snooze_ring", ring, 0);
    check("snooze_mask", snooze_mask, 4'b0010);
    clk1();
    check("snooze_idle", ring, 0);
    tick_at(0, 2, 0);
    check("snz_early", pend_mask, 0);
    tick_at(0, 3, 0);
    check("snz_pend", pend_mask, 4'b0010);
    check("snz_clear", snooze_mask, 0);
    second = 6'd1;
    clk1();
    check("snz_ring", ring, 1);
    check("snz_ring_idx", ring_idx, 1);
    press(B_MID);
    check("snz_dismiss", ring, 0);

    // Ring timeout after 3 ticks
    tick_at(7, 30, 0);
    second = 6'd1;
    clk1();
    check("to_ring", ring, 1);
    check("to_idx", ring_idx, 2);
    tick_at(7, 30, 1);
    check("to_tick1", ring, 1);
    tick_at(7, 30, 2);
    check("to_tick2", ring, 1);
    tick_at(7, 30, 3);
    check("to_tick3", ring, 0);
    check("to_en", en_mask, 4'b1111);

    // Match on the ringing channel re-queues it
    tick_at(7, 30, 0);
    second = 6'd1;
    clk1();
    check("rq_ring", ring, 1);
    tick_at(7, 30, 0);
    check("rq_pend", pend_mask, 4'b0100);
    check("rq_still", ring, 1);
    press(B_MID);
    check("rq_dismiss", ring, 0);
    clk1();
    check("rq_again", ring, 1);
    check("rq_again_idx", ring_idx, 2);
    press(B_MID);
    check("rq_done", ring, 0);
    check("rq_done_pend", pend_mask, 0);

    // Edit boundaries on channel 1 (23:58)
    edit_en = 1'b1; sel = 2'd1;
    press(B_RIGHT);
    press(B_UP);
    check("min_59", sel_minute, 59);
    press(B_UP);
    check("min_wrap", sel_minute, 0);
    check("min_wrap_hour", sel_hour, 23);
    press(B_LEFT);
    press(B_UP);
    check("hour_wrap", sel_hour, 0);
    press(B_DOWN);
    check("hour_back", sel_hour, 23);
    up = 1'b1; down = 1'b1;
    clk1();
    up = 1'b0; down = 1'b0;
    check("updown_hour", sel_hour, 23);
    press(B_RIGHT);
    press(B_DOWN);
    check("min_dec_wrap", sel_minute, 59);
    press(B_LEFT);
    press(B_MID);
    check("en_toggle_off", en_mask, 4'b1101);
    press(B_MID);
    check("en_toggle_on", en_mask, 4'b1111);
    edit_en = 1'b0;

    // Reset while ringing with channel 3 still pending
    tick_at(6, 0, 0);
    second = 6'd1;
    clk1();
    check("pre_rst_ring", ring, 1);
    check("pre_rst_pend", pend_mask, 4'b1000);
    rst = 1'b1;
    #1;
    check("arst_ring", ring, 0);
    check("arst_idx", ring_idx, 0);
    check("arst_pend", pend_mask, 0);
    check("arst_en", en_mask, 0);
    check("arst_snz", snooze_mask, 0);
    check("arst_hour", sel_hour, 0);
    check("arst_min", sel_minute, 0);
    check("arst_field", field, 0);
    clk1();
    rst = 1'b0;
    clk1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
